// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RISC-V datapath (R-type, lw, sw, beq).
// Optional jal support is compiled in when MULTICYCLE_JAL_EN is defined.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Opcode,
    input  logic       MemReady,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCSource,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JAL    = 4'd9
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
`ifdef MULTICYCLE_JAL_EN
    localparam logic [6:0] OP_JAL = 7'b1101111;
`endif

    state_t state;
    state_t nxt;
    logic   illegal;
    logic   badop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            illegal <= 1'b0;
        end else begin
            state <= nxt;
            if (state == DECODE && badop)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        badop = 1'b1;
        if (Opcode == OP_LW || Opcode == OP_SW || Opcode == OP_R || Opcode == OP_BEQ)
            badop = 1'b0;
`ifdef MULTICYCLE_JAL_EN
        if (Opcode == OP_JAL)
            badop = 1'b0;
`endif
    end

    // Moore outputs, except IRWrite/PCWrite in FETCH which follow MemReady
    always_comb begin
        nxt         = FETCH;
        ALUOp       = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 2'b00;
        RegWrite    = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
                nxt     = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b10;
                if (Opcode == OP_LW || Opcode == OP_SW)
                    nxt = MEMADR;
                else if (Opcode == OP_R)
                    nxt = EXEC;
                else if (Opcode == OP_BEQ)
                    nxt = BRANCH;
`ifdef MULTICYCLE_JAL_EN
                else if (Opcode == OP_JAL)
                    nxt = JAL;
`endif
                else
                    nxt = FETCH;
            end
            MEMADR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                nxt     = (Opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                nxt     = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                nxt      = MemReady ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 2'b01;
                ALUOp   = 2'b10;
                nxt     = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 2'b01;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
`ifdef MULTICYCLE_JAL_EN
            JAL: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b10;
                PCWrite  = 1'b1;
                PCSource = 1'b1;
            end
`endif
            default: nxt = FETCH;
        endcase
    end

    assign IllegalOp = illegal;
    assign State     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control; each instruction's
// state trace is built from the instruction type and stall counts.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [6:0] Opcode;
    logic       MemReady;
    logic [1:0] ALUOp, ALUSrcA, ALUSrcB, MemtoReg;
    logic       PCSource, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic       IRWrite, RegWrite, IllegalOp;
    logic [3:0] State;

    typedef struct packed {
        logic [1:0] aluop;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic       pcsrc;
        logic       pcwr;
        logic       pccond;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irwr;
        logic [1:0] m2r;
        logic       regwr;
    } outs_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    int errors = 0;
    int checks = 0;
    bit illegalSeen = 0;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .IllegalOp(IllegalOp),
        .State(State)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic outs_t observed();
        outs_t o;
        o = '{ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
              MemRead, MemWrite, IRWrite, MemtoReg, RegWrite};
        return o;
    endfunction

    // Expected control word for each step of the instruction sequence
    function automatic outs_t expOut(input int st, input bit mr);
        outs_t e;
        e = '0;
        case (st)
            0: begin e.mrd = 1; e.srcb = 2'b01; e.irwr = mr; e.pcwr = mr; end
            1: begin e.srca = 2'b10; e.srcb = 2'b10; end
            2: begin e.srca = 2'b01; e.srcb = 2'b10; end
            3: begin e.mrd = 1; e.iord = 1; end
            4: begin e.regwr = 1; e.m2r = 2'b01; end
            5: begin e.mwr = 1; e.iord = 1; end
            6: begin e.srca = 2'b01; e.aluop = 2'b10; end
            7: begin e.regwr = 1; end
            8: begin e.srca = 2'b01; e.aluop = 2'b01; e.pccond = 1; e.pcsrc = 1; end
            9: begin e.regwr = 1; e.m2r = 2'b10; e.pcwr = 1; e.pcsrc = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic bit jalEnabled();
`ifdef MULTICYCLE_JAL_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkCycle(input int st, input bit mr);
        checkOutput("State", {28'd0, State}, st);
        checkOutput("controls", {16'd0, observed()}, {16'd0, expOut(st, mr)});
        checkOutput("IllegalOp", {31'd0, IllegalOp}, {31'd0, illegalSeen});
    endtask

    // Runs one instruction; enters and leaves just after a rising edge
    task automatic applyStimulus(input logic [6:0] op, input int fStall, input int mStall);
        int sq[$];
        bit rq[$];
        bit bad;
        bad = !(op == OP_LW || op == OP_SW || op == OP_R || op == OP_BEQ ||
                (op == OP_JAL && jalEnabled()));
        for (int i = 0; i < fStall; i++) begin sq.push_back(0); rq.push_back(0); end
        sq.push_back(0); rq.push_back(1);
        sq.push_back(1); rq.push_back(1'($urandom_range(0, 1)));
        if (op == OP_LW || op == OP_SW) begin
            sq.push_back(2); rq.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < mStall; i++) begin
                sq.push_back(op == OP_LW ? 3 : 5); rq.push_back(0);
            end
            sq.push_back(op == OP_LW ? 3 : 5); rq.push_back(1);
            if (op == OP_LW) begin sq.push_back(4); rq.push_back(1'($urandom_range(0, 1))); end
        end else if (op == OP_R) begin
            sq.push_back(6); rq.push_back(1'($urandom_range(0, 1)));
            sq.push_back(7); rq.push_back(1'($urandom_range(0, 1)));
        end else if (op == OP_BEQ) begin
            sq.push_back(8); rq.push_back(1'($urandom_range(0, 1)));
        end else if (!bad) begin
            sq.push_back(9); rq.push_back(1'($urandom_range(0, 1)));
        end
        foreach (sq[i]) begin
            Opcode   = op;
            MemReady = rq[i];
            @(negedge clk);
            checkCycle(sq[i], rq[i]);
            if (sq[i] == 1 && bad) illegalSeen = 1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] op;
        rst_n    = 1'b0;
        Opcode   = 7'd0;
        MemReady = 1'b0;
        #2;
        checkCycle(0, 0);
        MemReady = 1'b1;
        #1;
        checkCycle(0, 1);
        @(posedge clk);
        #1;
        checkCycle(0, 1);
        rst_n = 1'b1;

        applyStimulus(OP_R, 0, 0);
        applyStimulus(OP_LW, 0, 2);
        applyStimulus(OP_BEQ, 0, 0);
        applyStimulus(OP_SW, 1, 1);
        applyStimulus(OP_JAL, 0, 0);
        applyStimulus(7'b1111111, 0, 0);
        applyStimulus(OP_R, 0, 0);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_R;
                3: op = OP_BEQ;
                4: op = OP_JAL;
                default: op = 7'($urandom);
            endcase
            applyStimulus(op, $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0,
                          $urandom_range(0, 2));
        end

        // Asynchronous reset while a store is waiting on memory
        Opcode   = OP_SW;
        MemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkCycle(i == 2 ? 2 : i, 1);
            if (i == 1 && illegalSeen == 0) checkOutput("IllegalOp pre", {31'd0, IllegalOp}, 32'd0);
            @(posedge clk);
            #1;
        end
        MemReady = 1'b0;
        #1;
        checkCycle(5, 0);
        rst_n = 1'b0;
        #1;
        illegalSeen = 0;
        checkCycle(0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(OP_BEQ, 0, 0);
        applyStimulus(OP_LW, 1, 0);
        Opcode   = OP_R;
        MemReady = 1'b0;
        @(negedge clk);
        checkCycle(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RISC-V datapath; it produces the `ALUOp` code that the ALU control decoder consumes, along with every datapath enable and mux select. The FSM sequences each instruction through fetch, decode, execute, memory and writeback steps, and stalls on a memory ready handshake. Supported opcodes: R-type, `lw`, `sw` and `beq`. `jal` is optional.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `Opcode`  in  7  instruction[6:0] from IR; stable from DECODE until the next FETCH
- `MemReady`  in  1  memory completes the current access this cycle
- `ALUOp`  out  2  00 add, 01 sub (branch compare), 10 R-type (use funct fields)
- `ALUSrcA`  out  2  00 PC, 01 rs1 register, 10 OldPC
- `ALUSrcB`  out  2  00 rs2 register, 01 constant 4, 10 immediate
- `PCSource`  out  1  0 ALU result, 1 ALUOut register
- `PCWrite`  out  1  unconditional PC load
- `PCWriteCond`  out  1  PC load when ALU Zero
- `IorD`  out  1  memory address: 0 PC, 1 ALUOut
- `MemRead`, `MemWrite`  out  1 each  memory strobes
- `IRWrite`  out  1  instruction register load
- `MemtoReg`  out  2  writeback data: 00 ALUOut, 01 MDR, 10 PC
- `RegWrite`  out  1  register file write
- `IllegalOp`  out  1  sticky flag; unsupported opcode was decoded
- `State`  out  4  current state, for debug

## Operation
- State register is 4 bits: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JAL=9.
- All outputs are decoded from `State` only (Moore), except `IRWrite` and `PCWrite` in FETCH, which are gated by `MemReady`.
- Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=0, IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch target into ALUOut). Next state by `Opcode`:
  - 0000011 (`lw`) or 0100011 (`sw`) → MEMADR
  - 0110011 (R-type) → EXEC
  - 1100011 (`beq`) → BRANCH
  - 1101111 (`jal`) → JAL, only when the macro is defined
  - anything else → FETCH, and IllegalOp is set
- MEMADR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Goes to MEMRD for `lw`, MEMWR for `sw`.
- MEMRD: MemRead=1, IorD=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=01, then FETCH.
- MEMWR: MemWrite=1, IorD=1. Waits for MemReady, then goes to FETCH.
- EXEC: ALUSrcA=01, ALUSrcB=00, ALUOp=10, then ALUWB.
- ALUWB: RegWrite=1, MemtoReg=00, then FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, then FETCH.
- JAL: RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=1, then FETCH.
- Unused encodings (10–15): all outputs 0; next state is FETCH.
- IllegalOp: set on the clock edge that leaves DECODE with an illegal opcode; cleared only by reset.

## Timing
- Reset (`rst_n`=0, asynchronous): State=FETCH, IllegalOp=0.
  - Outputs immediately take FETCH values: MemRead=1, ALUSrcB=01, IRWrite=PCWrite=MemReady, all others 0.
- Reset deasserted mid-instruction: the instruction is abandoned; fetch restarts at whatever PC the datapath holds.
- Cycle counts with MemReady=1 throughout:
  - `lw`: 5 cycles
  - `sw`: 4 cycles
  - R-type: 4 cycles
  - `beq`: 3 cycles
  - `jal`: 3 cycles
  - illegal opcode: 2 cycles
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes stay asserted and the address select stays stable while waiting.
- MemReady is ignored in all other states.
- MemRead and MemWrite are never asserted in the same cycle.

## Configuration
- Macro `MULTICYCLE_JAL_EN`.
- Defined: opcode 1101111 goes DECODE → JAL → FETCH, writing PC+4 to rd and loading PC from ALUOut.
- Undefined: JAL state logic is omitted. 1101111 is illegal: IllegalOp is set and the FSM returns to FETCH.

## Test plan
- Reset, then `rst_n`=1 with MemReady=1 → State 0→1; FETCH shows MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- Opcode=0110011, MemReady=1 → states 0,1,6,7,0. ALUOp=10 in EXEC; RegWrite=1 and MemtoReg=00 only in ALUWB.
- Opcode=0000011, MemReady low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0. MemRead=1 and IorD=1 held across the stall; RegWrite=1 with MemtoReg=01 in MEMWB.
- Opcode=1100011 → states 0,1,8,0. ALUOp=01, PCWriteCond=1, PCSource=1 in BRANCH; PCWrite=0.
- Opcode=1111111 → DECODE→FETCH, IllegalOp=1 and sticky across later valid instructions. Pulse `rst_n` low mid-MEMWR → immediately State=0, IllegalOp=0, MemWrite=0.
- Opcode=1101111 → with the macro: states 0,1,9,0, MemtoReg=10, PCWrite=1. Without the macro: IllegalOp=1.
